// File: rtl/c17_bist_pkg.sv
// Shared types and helpers for the C17 BIST array.
//  - state_t        : BIST controller states
//  - DEF_LFSR_POLY  : default pattern LFSR taps (x^20 + x^17 + 1)
//  - DEF_MISR_POLY  : default signature polynomial
//  - c17_eval       : behavioural C17, {G7,G6,G3,G2,G1} -> {G23,G22}
package c17_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [19:0] DEF_LFSR_POLY = 20'h90000;
    localparam logic [15:0] DEF_MISR_POLY = 16'h1021;

    function automatic logic [1:0] c17_eval(input logic [4:0] x);
        logic n10, n11, n16, n19;
        n10 = ~(x[0] & x[2]);
        n11 = ~(x[2] & x[3]);
        n16 = ~(x[1] & n11);
        n19 = ~(n11 & x[4]);
        return {~(n16 & n19), ~(n10 & n16)};
    endfunction

endpackage

// File: rtl/c17_bist_array_core.sv
// Gate-level ISCAS C17 core, purely combinational.
//  core_in [4:0] : {G7,G6,G3,G2,G1}
//  res_c   [1:0] : {G23,G22}
module c17_core
    import c17_bist_pkg::*;
(
    input  logic [4:0] core_in,
    output logic [1:0] res_c
);

    logic n10, n11, n16, n19;

    assign n10      = ~(core_in[0] & core_in[2]);
    assign n11      = ~(core_in[2] & core_in[3]);
    assign n16      = ~(core_in[1] & n11);
    assign n19      = ~(n11 & core_in[4]);
    assign res_c[0] = ~(n10 & n16);
    assign res_c[1] = ~(n16 & n19);

    // Gate netlist must agree with the behavioural reference.
    always_comb begin
        assert (res_c == c17_eval(core_in));
    end

endmodule

// File: rtl/c17_bist_array.sv
// Registered array of C17 cores with LFSR/MISR built-in self-test.
//  clk, reset (async, active-high)
//  start        : pulse, begins a BIST run from IDLE or DONE
//  func_in      : 5 bits per channel, {G7,G6,G3,G2,G1}
//  func_valid   : functional beat valid
//  fault_mask   : XORed onto core outputs ahead of stage 2 / MISR
//  func_out     : 2 bits per channel, {G23,G22}; holds when not valid
//  func_out_vld : functional result valid (2-cycle latency)
//  busy, done, pass, signature : BIST status and MISR contents
module c17_bist_array
    import c17_bist_pkg::*;
#(
    parameter int unsigned       CHANNELS     = 4,
    parameter int unsigned       LFSR_W       = 20,
    parameter logic [LFSR_W-1:0] LFSR_POLY    = LFSR_W'(DEF_LFSR_POLY),
    parameter logic [LFSR_W-1:0] LFSR_SEED    = LFSR_W'(1),
    parameter int unsigned       NUM_PATTERNS = 1000,
    parameter int unsigned       MISR_W       = 16,
    parameter logic [MISR_W-1:0] MISR_POLY    = MISR_W'(DEF_MISR_POLY),
    parameter logic [MISR_W-1:0] GOLDEN       = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [5*CHANNELS-1:0]   func_in,
    input  logic                    func_valid,
    input  logic [2*CHANNELS-1:0]   fault_mask,
    output logic [2*CHANNELS-1:0]   func_out,
    output logic                    func_out_vld,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [MISR_W-1:0]       signature
);

    localparam int unsigned IN_W  = 5 * CHANNELS;
    localparam int unsigned OUT_W = 2 * CHANNELS;
    localparam int unsigned CNT_W = $clog2(NUM_PATTERNS + 1);

    // A zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [LFSR_W-1:0] SEED = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;
    localparam logic [CNT_W-1:0]  LAST = CNT_W'(NUM_PATTERNS - 1);

    state_t             state;
    logic               flush_second;
    logic [CNT_W-1:0]   cnt;
    logic [LFSR_W-1:0]  lfsr;
    logic [MISR_W-1:0]  misr;
    logic [IN_W-1:0]    s1_in;
    logic               s1_vld;
    logic               s1_bist;
    logic [OUT_W-1:0]   s2_bist_out;
    logic               s2_bist;

    logic [IN_W-1:0]    pattern_c;
    logic [OUT_W-1:0]   core_res_c;
    logic [LFSR_W-1:0]  lfsr_raw_c;
    logic [LFSR_W-1:0]  lfsr_step_c;
    logic [MISR_W-1:0]  misr_d_c;
    logic               start_acc_c;
    logic               in_bist_c;

    // LFSR fan-out to the cores and one C17 instance per channel.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        for (genvar i = 0; i < 5; i++) begin : g_bit
            assign pattern_c[5*k+i] = lfsr[(5*k+i) % LFSR_W];
        end
        c17_core u_core (
            .core_in (s1_in[5*k +: 5]),
            .res_c   (core_res_c[2*k +: 2])
        );
    end

    // Next LFSR value; the all-zero guard only matters for degenerate tap sets.
    assign lfsr_raw_c  = {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_POLY)};
    assign lfsr_step_c = (lfsr_raw_c == '0) ? LFSR_W'(1) : lfsr_raw_c;

    // MISR next value; only advances behind a BIST beat in stage 2.
    assign misr_d_c = s2_bist
                    ? ({misr[MISR_W-2:0], 1'b0} ^ (misr[MISR_W-1] ? MISR_POLY : '0)
                       ^ MISR_W'(s2_bist_out))
                    : misr;

    assign in_bist_c   = (state == RUN) || (state == FLUSH);
    assign start_acc_c = start && ((state == IDLE) || (state == DONE));
    assign signature   = misr;

    // Pipeline, pattern generator, compactor and controller.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            flush_second <= 1'b0;
            cnt          <= '0;
            lfsr         <= SEED;
            misr         <= '0;
            s1_in        <= '0;
            s1_vld       <= 1'b0;
            s1_bist      <= 1'b0;
            s2_bist_out  <= '0;
            s2_bist      <= 1'b0;
            func_out     <= '0;
            func_out_vld <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
        end else begin
            // Stage 1: BIST patterns take over the input register while busy.
            s1_in   <= in_bist_c ? pattern_c : func_in;
            s1_vld  <= func_valid && !in_bist_c && !start_acc_c;
            s1_bist <= (state == RUN);

            // Stage 2: an accepted start also kills any functional beat in flight.
            if (s1_vld && !start_acc_c) begin
                func_out <= core_res_c ^ fault_mask;
            end
            func_out_vld <= s1_vld && !start_acc_c;
            if (s1_bist) begin
                s2_bist_out <= core_res_c ^ fault_mask;
            end
            s2_bist <= s1_bist;
            misr    <= misr_d_c;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= RUN;
                        flush_second <= 1'b0;
                        lfsr         <= SEED;
                        misr         <= '0;
                        cnt          <= '0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                    end
                end
                RUN: begin
                    lfsr <= lfsr_step_c;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    // Second flush cycle retires the last pattern into the MISR.
                    if (!flush_second) begin
                        flush_second <= 1'b1;
                    end else begin
                        flush_second <= 1'b0;
                        state        <= DONE;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        pass         <= (misr_d_c == GOLDEN);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_c17_bist_array.sv
// Self-checking bench for c17_bist_array (CHANNELS = 4, NUM_PATTERNS = 1000).
module tb_c17_bist_array;

    localparam int unsigned NP       = 1000;
    localparam int          BUSY_LEN = 1002;
    localparam int          TIMEOUT  = 5000;

    // Independent reference: C17 in sum-of-products form.
    function automatic logic [1:0] c17_ref(input logic [4:0] x);
        logic g1, g2, g3, g6, g7;
        {g7, g6, g3, g2, g1} = x;
        return {~(g3 & g6) & (g2 | g7), (g1 & g3) | (g2 & ~(g3 & g6))};
    endfunction

    function automatic logic [7:0] chan_ref(input logic [19:0] din);
        logic [7:0] r;
        for (int k = 0; k < 4; k++) r[2*k +: 2] = c17_ref(din[5*k +: 5]);
        return r;
    endfunction

    // Full-run signature model with a constant fault mask.
    function automatic logic [15:0] model_sig(input logic [7:0] mask);
        logic [19:0] l;
        logic [15:0] m;
        logic [19:0] din;
        logic [7:0]  res;
        l = 20'h00001;
        m = 16'h0000;
        for (int a = 0; a < 25; a++) begin
            for (int b = 0; b < 40; b++) begin
                for (int j = 0; j < 20; j++) din[j] = l[j];
                res = chan_ref(din) ^ mask;
                m = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {8'h00, res};
                l = {l[18:0], l[19] ^ l[16]};
                if (l == 20'h0) l = 20'h00001;
            end
        end
        return m;
    endfunction

    localparam logic [15:0] GOLD = model_sig(8'h00);

    logic        clk;
    logic        reset;
    logic        start;
    logic [19:0] func_in;
    logic        func_valid;
    logic [7:0]  fault_mask;
    logic [7:0]  func_out;
    logic        func_out_vld;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;

    c17_bist_array #(
        .CHANNELS     (4),
        .LFSR_W       (20),
        .LFSR_POLY    (20'h90000),
        .LFSR_SEED    (20'h00001),
        .NUM_PATTERNS (NP),
        .MISR_W       (16),
        .MISR_POLY    (16'h1021),
        .GOLDEN       (GOLD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .func_in      (func_in),
        .func_valid   (func_valid),
        .fault_mask   (fault_mask),
        .func_out     (func_out),
        .func_out_vld (func_out_vld),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .signature    (signature)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [19:0] din;
        logic        vld;
        logic [7:0]  dout;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to the next falling edge and retire any functional result.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (func_out_vld) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL func_out_vld: got 1 with no beat pending, expected 0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("func_out", 32'(func_out), 32'(e.data));
                chk("latency", 32'(cyc - e.cyc), 32'd2);
            end
        end
    endtask

    // One BIST run; optionally pokes start during RUN and FLUSH.
    task automatic run_bist(input bit poke, output int nbusy, output int ndone);
        start      = 1'b1;
        func_valid = 1'b1;
        func_in    = 20'hFFFFF;
        tick();
        start = 1'b0;
        nbusy = 0;
        ndone = 0;
        while (busy && nbusy < TIMEOUT) begin
            nbusy++;
            if (done) ndone++;
            func_in    = 20'($urandom);
            func_valid = 1'($urandom);
            start      = poke && (nbusy == 5 || nbusy >= int'(NP));
            tick();
        end
        start      = 1'b0;
        func_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int nbusy, ndone;

        vecs[0]  = '{20'hFFFFF, 1'b1, 8'h55};
        vecs[1]  = '{20'h00000, 1'b1, 8'h00};
        vecs[2]  = '{20'hFFFFF, 1'b1, 8'h55};
        vecs[3]  = '{20'h00000, 1'b1, 8'h00};
        vecs[4]  = '{20'hFFFFF, 1'b1, 8'h55};
        vecs[5]  = '{20'h00000, 1'b1, 8'h00};
        vecs[6]  = '{20'h83586, 1'b1, 8'h93};
        vecs[7]  = '{20'h0CA0D, 1'b1, 8'h39};
        vecs[8]  = '{20'h12345, 1'b0, 8'h00};
        vecs[9].din  = 20'($urandom);
        vecs[9].vld  = 1'b1;
        vecs[9].dout = chan_ref(vecs[9].din);
        vecs[10].din  = 20'($urandom);
        vecs[10].vld  = 1'b1;
        vecs[10].dout = chan_ref(vecs[10].din);
        vecs[11] = '{20'h0CA0D, 1'b1, 8'h39};

        reset      = 1'b1;
        start      = 1'b0;
        func_in    = '0;
        func_valid = 1'b0;
        fault_mask = '0;
        tick();
        tick();
        chk("rst_func_out", 32'(func_out), 0);
        chk("rst_vld", 32'(func_out_vld), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_signature", 32'(signature), 0);
        reset = 1'b0;
        tick();

        // Back-to-back functional stream with one bubble.
        for (int v = 0; v < 12; v++) begin
            func_in    = vecs[v].din;
            func_valid = vecs[v].vld;
            if (vecs[v].vld) sb.push_back('{vecs[v].dout, cyc});
            tick();
        end
        func_valid = 1'b0;
        tick();
        tick();
        for (int h = 0; h < 3; h++) begin
            func_in = 20'($urandom);
            tick();
            chk("hold_func_out", 32'(func_out), 32'h39);
            chk("hold_vld", 32'(func_out_vld), 0);
        end
        chk("sb_empty_func", 32'(sb.size()), 0);

        // Fault mask on the functional path.
        fault_mask = 8'hA5;
        func_valid = 1'b1;
        func_in    = 20'hFFFFF;
        sb.push_back('{8'h55 ^ 8'hA5, cyc});
        tick();
        func_in = 20'h00000;
        sb.push_back('{8'h00 ^ 8'hA5, cyc});
        tick();
        func_valid = 1'b0;
        tick();
        tick();
        fault_mask = 8'h00;
        tick();
        chk("sb_empty_mask", 32'(sb.size()), 0);

        // Fault-free run.
        run_bist(1'b0, nbusy, ndone);
        chk("bist_busy_len", 32'(nbusy), 32'(BUSY_LEN));
        chk("bist_done", 32'(done), 1);
        chk("bist_signature", 32'(signature), 32'(GOLD));
        chk("bist_pass", 32'(pass), 1);
        tick();
        chk("bist_done_held", 32'(done), 1);

        // Stuck fault on channel 0 for the whole run.
        fault_mask = 8'h01;
        run_bist(1'b0, nbusy, ndone);
        fault_mask = 8'h00;
        chk("fault_busy_len", 32'(nbusy), 32'(BUSY_LEN));
        chk("fault_done", 32'(done), 1);
        chk("fault_pass", 32'(pass), 0);
        chk("fault_signature", 32'(signature), 32'(model_sig(8'h01)));
        chk("fault_sig_differs", 32'(signature != GOLD), 1);

        // Reset in the middle of RUN.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 500 && busy; c++) tick();
        chk("mid_busy_before_reset", 32'(busy), 1);
        reset = 1'b1;
        tick();
        sb.delete();
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_pass", 32'(pass), 0);
        chk("mid_rst_signature", 32'(signature), 0);
        reset = 1'b0;
        tick();
        run_bist(1'b0, nbusy, ndone);
        chk("after_rst_busy_len", 32'(nbusy), 32'(BUSY_LEN));
        chk("after_rst_signature", 32'(signature), 32'(GOLD));
        chk("after_rst_pass", 32'(pass), 1);

        // Start pulses in RUN and FLUSH are ignored.
        run_bist(1'b1, nbusy, ndone);
        chk("poke_busy_len", 32'(nbusy), 32'(BUSY_LEN));
        chk("poke_signature", 32'(signature), 32'(GOLD));
        chk("poke_done", 32'(done), 1);

        // Restart from DONE: done stays low for the whole rerun.
        run_bist(1'b0, nbusy, ndone);
        chk("rerun_busy_len", 32'(nbusy), 32'(BUSY_LEN));
        chk("rerun_done_while_busy", 32'(ndone), 0);
        chk("rerun_done", 32'(done), 1);
        chk("rerun_pass", 32'(pass), 1);
        tick();
        chk("sb_empty_end", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
